// File: rtl/seq_match_pkg.sv
// rtl/seq_match_pkg.sv - shared state type, default pattern and width helpers
package seq_match_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int DEF_PLEN = 5;
  localparam logic [DEF_PLEN-1:0] DEF_PAT = 5'b11101;

  // Requester id width; a single requester still gets one bit.
  function automatic int id_width(input int nreq);
    return (nreq <= 1) ? 1 : $clog2(nreq);
  endfunction

  // Match counter width able to hold 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_match_scheduler_if.sv
// rtl/seq_match_scheduler_if.sv - requester and result bundle of the shared matcher
interface seq_match_scheduler_if
  import seq_match_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = id_width(NREQ),
  parameter int CNTW = cnt_width(W)
);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              done;
  logic [IDW-1:0]    done_id;
  logic [CNTW-1:0]   done_count;
  logic              done_hit;

  // Producers drive requests and words, and watch grants and results.
  modport master (
    output req, req_data,
    input  gnt, busy, done, done_id, done_count, done_hit
  );

  // The scheduler consumes requests and publishes grants and results.
  modport slave (
    input  req, req_data,
    output gnt, busy, done, done_id, done_count, done_hit
  );

endinterface

// File: rtl/seq_match_scheduler_pattern_window.sv
// rtl/seq_match_scheduler_pattern_window.sv - serial pattern detector with per-job fill tracking
module pattern_window
  import seq_match_pkg::*;
#(
  parameter int              PLEN = DEF_PLEN,
  parameter logic [PLEN-1:0] PAT  = DEF_PAT
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic hit
);

  localparam int FW = $clog2(PLEN);
  localparam logic [FW-1:0] FULL = FW'(PLEN - 1);

  // Only the last PLEN-1 bits are stored; the incoming bit completes the window.
  logic [PLEN-2:0] hist;
  logic [FW-1:0]   fill;
  logic [PLEN-1:0] window;

  assign window = {hist, din};
  assign hit    = (window == PAT) && (fill == FULL);

  // History shifts on each enabled bit; fill saturates once a full window exists.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= window[PLEN-2:0];
      if (fill != FULL) begin
        fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_match_scheduler.sv
// rtl/seq_match_scheduler.sv - round-robin sharing of one serial pattern matcher
module seq_match_scheduler
  import seq_match_pkg::*;
#(
  parameter int              NREQ = 4,
  parameter int              W    = 16,
  parameter int              PLEN = DEF_PLEN,
  parameter logic [PLEN-1:0] PAT  = DEF_PAT,
  parameter int              IDW  = id_width(NREQ),
  parameter int              CNTW = cnt_width(W)
) (
  input logic            clock,
  input logic            reset,
  seq_match_scheduler_if.slave bus
);

  state_t          state;
  state_t          state_next;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  pick_id;
  logic            pick_valid;
  logic [IDW-1:0]  scan_id;
  int              scan;
  logic [IDW-1:0]  job_id;
  logic [W-1:0]    shreg;
  logic [CNTW-1:0] bit_cnt;
  logic [CNTW-1:0] match_cnt;
  logic            last_bit;
  logic            win_clr;
  logic            win_en;
  logic            win_din;
  logic            win_hit;

  assign last_bit = (bit_cnt == CNTW'(W - 1));
  assign bus.busy = (state != IDLE);

  // Round-robin pick: first asserted request at or above the pointer, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    scan       = 0;
    scan_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = int'(ptr) + k;
      if (scan >= NREQ) begin
        scan = scan - NREQ;
      end
      scan_id = IDW'(scan);
      if (bus.req[scan_id]) begin
        pick_valid = 1'b1;
        pick_id    = scan_id;
      end
    end
  end

  // Next-state logic and matcher controls.
  always_comb begin
    state_next = state;
    win_clr    = 1'b0;
    win_en     = 1'b0;
    win_din    = shreg[W-1];
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = SHIFT;
          win_clr    = 1'b1;
        end
      end
      SHIFT: begin
        win_en = 1'b1;
        if (last_bit) begin
          state_next = REPORT;
        end
      end
      REPORT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Job datapath: capture on grant, shift MSB-first, publish results on the last bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr            <= '0;
      job_id         <= '0;
      shreg          <= '0;
      bit_cnt        <= '0;
      match_cnt      <= '0;
      bus.gnt        <= '0;
      bus.done       <= 1'b0;
      bus.done_id    <= '0;
      bus.done_count <= '0;
      bus.done_hit   <= 1'b0;
    end else begin
      bus.gnt        <= '0;
      bus.done       <= 1'b0;
      bus.done_id    <= '0;
      bus.done_count <= '0;
      bus.done_hit   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            shreg     <= bus.req_data[int'(pick_id)*W +: W];
            job_id    <= pick_id;
            bit_cnt   <= '0;
            match_cnt <= '0;
            bus.gnt   <= NREQ'(1) << pick_id;
            ptr       <= (pick_id == IDW'(NREQ - 1)) ? '0 : pick_id + 1'b1;
          end
        end
        SHIFT: begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (win_hit) begin
            match_cnt <= match_cnt + 1'b1;
          end
          if (last_bit) begin
            bus.done       <= 1'b1;
            bus.done_id    <= job_id;
            bus.done_count <= match_cnt + CNTW'(win_hit);
            bus.done_hit   <= (match_cnt != '0) || win_hit;
          end
        end
        default: begin
        end
      endcase
    end
  end

  pattern_window #(
    .PLEN (PLEN),
    .PAT  (PAT)
  ) u_window (
    .clock (clock),
    .reset (reset),
    .clr   (win_clr),
    .en    (win_en),
    .din   (win_din),
    .hit   (win_hit)
  );

endmodule

// File: tb/tb_seq_match_scheduler.sv
// tb/tb_seq_match_scheduler.sv - directed self-checking bench for seq_match_scheduler
module tb_seq_match_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  seq_match_scheduler_if #(.NREQ(NREQ), .W(W), .IDW(2), .CNTW(5)) bus ();

  seq_match_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    bus.req      = '0;
    bus.req_data = '0;
    reset        = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic run_job(input int id, input logic [15:0] data, input int exp_count, input string tag);
    int   n;
    logic seen;
    @(posedge clock);
    #1;
    bus.req_data[id*W +: W] = data;
    bus.req[id]             = 1'b1;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 40) begin
      @(negedge clock);
      n++;
      if (bus.gnt != '0) seen = 1'b1;
    end
    bus.req[id] = 1'b0;
    if (!seen) begin
      check({tag, "_gnt_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(1 << id));
    check({tag, "_gnt_cycle"}, n, 32'd2);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 40) begin
      @(negedge clock);
      n++;
      if (n == 1) check({tag, "_gnt_pulse"}, 32'(bus.gnt), 32'd0);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_done_latency"}, n, 32'd16);
    check({tag, "_done_id"}, 32'(bus.done_id), 32'(id));
    check({tag, "_done_count"}, 32'(bus.done_count), 32'(exp_count));
    check({tag, "_done_hit"}, 32'(bus.done_hit), 32'(exp_count != 0));
    check({tag, "_busy_report"}, 32'(bus.busy), 32'd1);
    @(negedge clock);
    check({tag, "_done_clear"}, 32'(bus.done), 32'd0);
    check({tag, "_count_clear"}, 32'(bus.done_count), 32'd0);
    check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int   k;
    int   cyc;
    int   last_cyc;
    int   gid;
    int   last_gid;
    int   n;
    int   pulses;
    logic seen;

    do_reset();
    @(negedge clock);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_done_id", 32'(bus.done_id), 32'd0);
    check("rst_done_count", 32'(bus.done_count), 32'd0);
    check("rst_done_hit", 32'(bus.done_hit), 32'd0);

    run_job(0, 16'hE800, 1, "single");
    run_job(1, 16'hEE80, 2, "overlap");
    run_job(2, 16'h0000, 0, "zeros");
    run_job(2, 16'hFFFF, 0, "ones");

    // Fairness: all four held, each dropped after its grant, then re-raised.
    do_reset();
    @(posedge clock);
    #1;
    bus.req_data = {4{16'hE800}};
    bus.req      = 4'b1111;
    k        = 0;
    cyc      = 0;
    last_cyc = 0;
    last_gid = -1;
    while (k < 8 && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (bus.done) begin
        check("rr_done_id", 32'(bus.done_id), 32'(last_gid));
        check("rr_done_count", 32'(bus.done_count), 32'd1);
      end
      if (bus.gnt != '0) begin
        gid = 0;
        for (int b = 0; b < NREQ; b++) if (bus.gnt[b]) gid = b;
        check("rr_onehot", 32'($countones(bus.gnt)), 32'd1);
        check("rr_order", gid, k % 4);
        if (k > 0) check("rr_spacing", cyc - last_cyc, 32'd18);
        last_cyc    = cyc;
        last_gid    = gid;
        bus.req[gid] = 1'b0;
        k++;
        if (k == 4) bus.req = 4'b1111;
      end
    end
    check("rr_grants", k, 32'd8);
    bus.req = '0;
    n = 0;
    while (bus.busy && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("rr_drain", 32'(bus.busy), 32'd0);

    // Cross-word boundary: no match may span two jobs.
    run_job(0, 16'h000E, 0, "bnd_a");
    run_job(1, 16'h8000, 0, "bnd_b");

    // Reset during cycle 8 of a job.
    @(posedge clock);
    #1;
    bus.req_data[15:0] = 16'hE800;
    bus.req[0]         = 1'b1;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 40) begin
      @(negedge clock);
      n++;
      if (bus.gnt != '0) seen = 1'b1;
    end
    bus.req[0] = 1'b0;
    check("mid_gnt_seen", 32'(seen), 32'd1);
    repeat (7) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_done", 32'(bus.done), 32'd0);
    check("mid_gnt", 32'(bus.gnt), 32'd0);
    check("mid_count", 32'(bus.done_count), 32'd0);
    pulses = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.done) pulses++;
    end
    check("mid_no_done", pulses, 32'd0);
    run_job(3, 16'hE800, 1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
